// File: rtl/noc_uart_pkg.sv
// Shared types and constants for the UART flit scheduler.
// Frame header is a magic nibble plus the requester id.
package noc_uart_pkg;

  localparam int BYTE_W = 8;
  localparam logic [3:0] HDR_MAGIC = 4'hA;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT
  } sched_state_t;

  function automatic logic [BYTE_W-1:0] hdr_byte(
    input logic [3:0] id
  );
    return {HDR_MAGIC, id};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches from ptr+1 upward, wrapping modulo N.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    idx    = '0;
    found  = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

endmodule

// File: rtl/uart_flit_sched.sv
// Round-robin flit scheduler feeding one shared UART byte transmitter.
// Sends header + payload bytes LSB first; watchdog aborts stalled frames.
module uart_flit_sched
  import noc_uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYC = 2**20
) (
  input  logic                          clk,
  input  logic                          nreset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [BYTE_W-1:0]             tx_data_byte,
  output logic                          tx_send_en,
  input  logic                          tx_done,
  input  logic                          err_clr,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          frame_done,
  output logic                          timeout_err
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int BYTES = DATA_WIDTH / BYTE_W;
  localparam int CNT_W = $clog2(BYTES + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYC);

  sched_state_t    state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] win_id;
  logic [NUM_REQ-1:0] gnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [CNT_W-1:0] byte_cnt;
  logic [WD_W-1:0]  wd;
  logic hs;
  logic last_byte;
  logic wd_fire;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .gnt   (gnt),
    .gnt_id(win_id)
  );

  assign req_ready = (nreset && state == IDLE) ? gnt : '0;
  assign hs        = |req_ready;
  assign busy      = (state != IDLE);
  assign last_byte = (byte_cnt == CNT_W'(BYTES));
  // fires on the increment that would reach TIMEOUT_CYC-1
  assign wd_fire   = (wd == WD_W'(TIMEOUT_CYC - 2));

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state        <= IDLE;
      rr_ptr       <= ID_W'(NUM_REQ - 1);
      grant_id     <= '0;
      shreg        <= '0;
      byte_cnt     <= '0;
      wd           <= '0;
      tx_send_en   <= 1'b0;
      tx_data_byte <= '0;
      frame_done   <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      tx_send_en <= 1'b0;
      frame_done <= 1'b0;
      if (err_clr)
        timeout_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (hs) begin
            shreg <= req_data[win_id*DATA_WIDTH +: DATA_WIDTH];
            grant_id     <= win_id;
            rr_ptr       <= win_id;
            byte_cnt     <= '0;
            tx_data_byte <= hdr_byte(4'(win_id));
            tx_send_en   <= 1'b1;
            state        <= SEND;
          end
        end
        SEND: begin
          wd    <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (tx_done) begin
            if (last_byte) begin
              frame_done <= 1'b1;
              state      <= IDLE;
            end else begin
              byte_cnt     <= byte_cnt + CNT_W'(1);
              tx_data_byte <= shreg[BYTE_W-1:0];
              shreg        <= shreg >> BYTE_W;
              tx_send_en   <= 1'b1;
              state        <= SEND;
            end
          end else if (wd_fire) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            wd <= wd + WD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_flit_sched.sv
// Scoreboard bench for uart_flit_sched: a 32-bit instance (short watchdog)
// and a 64-bit instance, each with a UART model answering 10 cycles later.
module tb_uart_flit_sched;

  logic clk;
  logic nreset;

  logic [3:0]   req_valid_a;
  logic [127:0] req_data_a;
  logic [3:0]   req_ready_a;
  logic [7:0]   tx_data_byte_a;
  logic         tx_send_en_a;
  logic         tx_done_a;
  logic         err_clr_a;
  logic         busy_a;
  logic [1:0]   grant_id_a;
  logic         frame_done_a;
  logic         timeout_err_a;

  logic [3:0]   req_valid_b;
  logic [255:0] req_data_b;
  logic [3:0]   req_ready_b;
  logic [7:0]   tx_data_byte_b;
  logic         tx_send_en_b;
  logic         tx_done_b;
  logic         err_clr_b;
  logic         busy_b;
  logic [1:0]   grant_id_b;
  logic         frame_done_b;
  logic         timeout_err_b;

  logic model_done_a, model_done_b, stray_a, uart_on_a;
  int   cnt_a, cnt_b;

  int tests, fails, cyc;
  int sends_a, dones_a, send_cyc_a, err_cyc_a;
  int sends_b, dones_b;
  bit prev_rdy_a, prev_err_a, prev_rdy_b;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  int got_q_a[$];
  int got_q_b[$];
  logic [7:0] e;

  assign tx_done_a = model_done_a | stray_a;
  assign tx_done_b = model_done_b;

  uart_flit_sched #(
    .NUM_REQ(4), .DATA_WIDTH(32), .TIMEOUT_CYC(16)
  ) dut_a (
    .clk(clk), .nreset(nreset),
    .req_valid(req_valid_a), .req_data(req_data_a),
    .req_ready(req_ready_a), .tx_data_byte(tx_data_byte_a),
    .tx_send_en(tx_send_en_a), .tx_done(tx_done_a),
    .err_clr(err_clr_a), .busy(busy_a), .grant_id(grant_id_a),
    .frame_done(frame_done_a), .timeout_err(timeout_err_a)
  );

  uart_flit_sched #(
    .NUM_REQ(4), .DATA_WIDTH(64), .TIMEOUT_CYC(64)
  ) dut_b (
    .clk(clk), .nreset(nreset),
    .req_valid(req_valid_b), .req_data(req_data_b),
    .req_ready(req_ready_b), .tx_data_byte(tx_data_byte_b),
    .tx_send_en(tx_send_en_b), .tx_done(tx_done_b),
    .err_clr(err_clr_b), .busy(busy_b), .grant_id(grant_id_b),
    .frame_done(frame_done_b), .timeout_err(timeout_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // monitors and UART models, all evaluated at the falling edge
  always @(negedge clk) begin
    cyc++;
    if (nreset) begin
      if (tx_send_en_a) begin
        sends_a++;
        send_cyc_a = cyc;
        tests++;
        if (q_a.size() == 0) begin
          fails++;
          $display("FAIL byte_a: got %h, none expected", tx_data_byte_a);
        end else begin
          e = q_a.pop_front();
          if (tx_data_byte_a !== e) begin
            fails++;
            $display("FAIL byte_a: got %h expected %h", tx_data_byte_a, e);
          end
        end
      end
      if (frame_done_a) begin
        dones_a++;
        tests++;
        if (model_done_a !== 1'b1) begin
          fails++;
          $display("FAIL frame_done_a: done_prev=%b expected 1", model_done_a);
        end
      end
      if (timeout_err_a && !prev_err_a) err_cyc_a = cyc;
      prev_err_a = timeout_err_a;
      if (req_ready_a != 0) begin
        tests++;
        if (!$onehot(req_ready_a) || |(req_ready_a & ~req_valid_a) || prev_rdy_a) begin
          fails++;
          $display("FAIL ready_a: got %b valid %b prev %b", req_ready_a, req_valid_a, prev_rdy_a);
        end
        for (int i = 0; i < 4; i++)
          if (req_ready_a[i]) got_q_a.push_back(i);
      end
      prev_rdy_a = |req_ready_a;
      model_done_a = 1'b0;
      if (cnt_a > 0) begin
        cnt_a--;
        if (cnt_a == 0) model_done_a = 1'b1;
      end
      if (tx_send_en_a && uart_on_a) cnt_a = 9;

      if (tx_send_en_b) begin
        sends_b++;
        tests++;
        if (q_b.size() == 0) begin
          fails++;
          $display("FAIL byte_b: got %h, none expected", tx_data_byte_b);
        end else begin
          e = q_b.pop_front();
          if (tx_data_byte_b !== e) begin
            fails++;
            $display("FAIL byte_b: got %h expected %h", tx_data_byte_b, e);
          end
        end
      end
      if (frame_done_b) dones_b++;
      if (req_ready_b != 0) begin
        tests++;
        if (!$onehot(req_ready_b) || prev_rdy_b) begin
          fails++;
          $display("FAIL ready_b: got %b prev %b", req_ready_b, prev_rdy_b);
        end
        for (int i = 0; i < 4; i++)
          if (req_ready_b[i]) got_q_b.push_back(i);
      end
      prev_rdy_b = |req_ready_b;
      model_done_b = 1'b0;
      if (cnt_b > 0) begin
        cnt_b--;
        if (cnt_b == 0) model_done_b = 1'b1;
      end
      if (tx_send_en_b) cnt_b = 9;
    end else begin
      model_done_a = 1'b0;
      model_done_b = 1'b0;
      cnt_a = 0;
      cnt_b = 0;
      prev_rdy_a = 1'b0;
      prev_rdy_b = 1'b0;
      prev_err_a = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    nreset = 1'b0;
    req_valid_a = '0;
    req_valid_b = '0;
    q_a.delete();
    q_b.delete();
    got_q_a.delete();
    got_q_b.delete();
    repeat (2) tick();
    nreset = 1'b1;
    tick();
  endtask

  task automatic wait_grant_a(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      #1;
      ok = (got_q_a.size() >= n);
    end
  endtask

  task automatic wait_done_a(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      #1;
      ok = (dones_a >= n);
    end
  endtask

  task automatic test_reset();
    req_valid_a = '1;
    req_valid_b = '1;
    #20;
    tests += 6;
    if (req_ready_a !== 4'b0) begin
      fails++; $display("FAIL rst_ready: got %b expected 0000", req_ready_a);
    end
    if (tx_send_en_a !== 1'b0 || tx_send_en_b !== 1'b0) begin
      fails++; $display("FAIL rst_send: got %b%b expected 00", tx_send_en_a, tx_send_en_b);
    end
    if (tx_data_byte_a !== 8'h00) begin
      fails++; $display("FAIL rst_byte: got %h expected 00", tx_data_byte_a);
    end
    if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
      fails++; $display("FAIL rst_busy: got %b%b expected 00", busy_a, busy_b);
    end
    if (grant_id_a !== 2'd0) begin
      fails++; $display("FAIL rst_grant: got %0d expected 0", grant_id_a);
    end
    if ({frame_done_a, timeout_err_a} !== 2'b00) begin
      fails++; $display("FAIL rst_flags: got %b%b expected 00", frame_done_a, timeout_err_a);
    end
    req_valid_a = '0;
    req_valid_b = '0;
    tick();
    nreset = 1'b1;
    repeat (4) tick();
    tests++;
    if (busy_a !== 1'b0 || sends_a != 0) begin
      fails++; $display("FAIL idle_quiet: busy %b sends %0d expected 0 0", busy_a, sends_a);
    end
  endtask

  task automatic test_single();
    bit ok;
    int s0 = sends_a;
    int d0 = dones_a;
    got_q_a.delete();
    req_data_a[2*32 +: 32] = 32'hDEADBEEF;
    q_a.push_back(8'hA2); q_a.push_back(8'hEF); q_a.push_back(8'hBE);
    q_a.push_back(8'hAD); q_a.push_back(8'hDE);
    req_valid_a = 4'b0100;
    wait_grant_a(1, 20, ok);
    tick();
    req_valid_a = '0;
    wait_done_a(d0 + 1, 100, ok);
    repeat (3) @(negedge clk);
    #1;
    tests += 4;
    if (!ok) begin
      fails++; $display("FAIL single_done: got no frame_done expected 1");
    end
    if (sends_a - s0 != 5 || q_a.size() != 0) begin
      fails++; $display("FAIL single_sends: got %0d left %0d expected 5 0", sends_a - s0, q_a.size());
    end
    if (dones_a - d0 != 1) begin
      fails++; $display("FAIL single_dones: got %0d expected 1", dones_a - d0);
    end
    if (grant_id_a !== 2'd2 || busy_a !== 1'b0) begin
      fails++; $display("FAIL single_grant: got %0d busy %b expected 2 0", grant_id_a, busy_a);
    end
  endtask

  task automatic test_rr();
    bit ok;
    int d0;
    logic [31:0] d[4];
    int order[5] = '{0, 1, 2, 3, 0};
    apply_reset();
    d0 = dones_a;
    for (int i = 0; i < 4; i++) begin
      d[i] = {8'h10 + 8'(i), 8'h20 + 8'(i), 8'h30 + 8'(i), 8'h40 + 8'(i)};
      req_data_a[i*32 +: 32] = d[i];
    end
    for (int g = 0; g < 5; g++) begin
      q_a.push_back({4'hA, 4'(order[g])});
      for (int k = 0; k < 4; k++)
        q_a.push_back(8'(d[order[g]] >> (8 * k)));
    end
    req_valid_a = 4'b1111;
    wait_grant_a(5, 400, ok);
    tick();
    req_valid_a = '0;
    tests++;
    if (!ok) begin
      fails++; $display("FAIL rr_grants: got %0d grants expected 5", got_q_a.size());
    end
    wait_done_a(d0 + 5, 100, ok);
    for (int g = 0; g < 5; g++) begin
      tests++;
      if (g >= got_q_a.size() || got_q_a[g] != order[g]) begin
        fails++;
        $display("FAIL rr_order[%0d]: got %0d expected %0d", g,
                 (g < got_q_a.size()) ? got_q_a[g] : -1, order[g]);
      end
    end
    tests++;
    if (!ok || q_a.size() != 0) begin
      fails++; $display("FAIL rr_frames: done %b left %0d expected 1 0", ok, q_a.size());
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int s0, d0;
    apply_reset();
    uart_on_a = 1'b0;
    s0 = sends_a;
    d0 = dones_a;
    req_data_a[1*32 +: 32] = 32'h55667788;
    q_a.push_back(8'hA1);
    req_valid_a = 4'b0010;
    wait_grant_a(1, 20, ok);
    tick();
    req_valid_a = '0;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      #1;
      ok = timeout_err_a;
    end
    tests += 4;
    if (!ok) begin
      fails++; $display("FAIL to_flag: got 0 expected 1");
    end
    if (err_cyc_a - send_cyc_a != 16) begin
      fails++; $display("FAIL to_delay: got %0d expected 16", err_cyc_a - send_cyc_a);
    end
    if (busy_a !== 1'b0) begin
      fails++; $display("FAIL to_busy: got %b expected 0", busy_a);
    end
    if (sends_a - s0 != 1 || dones_a != d0) begin
      fails++; $display("FAIL to_abort: sends %0d dones %0d expected 1 0", sends_a - s0, dones_a - d0);
    end
    repeat (5) @(negedge clk);
    tests++;
    if (timeout_err_a !== 1'b1) begin
      fails++; $display("FAIL to_sticky: got %b expected 1", timeout_err_a);
    end
    tick();
    err_clr_a = 1'b1;
    tick();
    err_clr_a = 1'b0;
    @(negedge clk);
    tests++;
    if (timeout_err_a !== 1'b0) begin
      fails++; $display("FAIL to_clear: got %b expected 0", timeout_err_a);
    end
    uart_on_a = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int k = 0;
    int s0, d0;
    apply_reset();
    s0 = sends_a;
    req_data_a[0 +: 32] = 32'hA1B2C3D4;
    q_a.push_back(8'hA0);
    q_a.push_back(8'hD4);
    req_valid_a = 4'b0001;
    for (int i = 0; i < 60 && k < 2; i++) begin
      @(posedge clk);
      if (tx_done_a) k++;
    end
    #1;
    nreset = 1'b0;
    #1;
    tests += 4;
    if (k != 2) begin
      fails++; $display("FAIL mid_dones: got %0d expected 2", k);
    end
    if (tx_send_en_a !== 1'b0 || busy_a !== 1'b0) begin
      fails++; $display("FAIL mid_rst_ctl: send %b busy %b expected 0 0", tx_send_en_a, busy_a);
    end
    if (req_ready_a !== 4'b0 || grant_id_a !== 2'd0 || tx_data_byte_a !== 8'h00) begin
      fails++;
      $display("FAIL mid_rst_out: ready %b grant %0d byte %h expected 0000 0 00",
               req_ready_a, grant_id_a, tx_data_byte_a);
    end
    if (sends_a - s0 != 2 || q_a.size() != 0) begin
      fails++; $display("FAIL mid_partial: sends %0d left %0d expected 2 0", sends_a - s0, q_a.size());
    end
    q_a.delete();
    got_q_a.delete();
    repeat (2) tick();
    s0 = sends_a;
    d0 = dones_a;
    q_a.push_back(8'hA0); q_a.push_back(8'hD4); q_a.push_back(8'hC3);
    q_a.push_back(8'hB2); q_a.push_back(8'hA1);
    nreset = 1'b1;
    wait_grant_a(1, 20, ok);
    tick();
    req_valid_a = '0;
    wait_done_a(d0 + 1, 100, ok);
    tests += 2;
    if (!ok || sends_a - s0 != 5 || q_a.size() != 0) begin
      fails++;
      $display("FAIL mid_restart: done %b sends %0d left %0d expected 1 5 0", ok, sends_a - s0, q_a.size());
    end
    if (got_q_a.size() != 1 || grant_id_a !== 2'd0) begin
      fails++; $display("FAIL mid_grant: grants %0d id %0d expected 1 0", got_q_a.size(), grant_id_a);
    end
  endtask

  task automatic test_stray();
    bit ok;
    int s0 = sends_a;
    int d0 = dones_a;
    got_q_a.delete();
    tick();
    stray_a = 1'b1;
    tick();
    stray_a = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (busy_a !== 1'b0 || sends_a != s0) begin
      fails++; $display("FAIL stray_idle: busy %b sends %0d expected 0 0", busy_a, sends_a - s0);
    end
    req_data_a[3*32 +: 32] = 32'h0BADF00D;
    q_a.push_back(8'hA3); q_a.push_back(8'h0D); q_a.push_back(8'hF0);
    q_a.push_back(8'hAD); q_a.push_back(8'h0B);
    req_valid_a = 4'b1000;
    wait_grant_a(1, 20, ok);
    tick();
    stray_a = 1'b1;
    req_valid_a = 4'b0001;
    @(negedge clk);
    tests++;
    if (req_ready_a !== 4'b0) begin
      fails++; $display("FAIL stray_ready_send: got %b expected 0000", req_ready_a);
    end
    tick();
    stray_a = 1'b0;
    @(negedge clk);
    tests++;
    if (req_ready_a !== 4'b0) begin
      fails++; $display("FAIL stray_ready_wait: got %b expected 0000", req_ready_a);
    end
    tick();
    req_valid_a = '0;
    wait_done_a(d0 + 1, 100, ok);
    repeat (3) @(negedge clk);
    tests++;
    if (!ok || sends_a - s0 != 5 || q_a.size() != 0 || got_q_a.size() != 1) begin
      fails++;
      $display("FAIL stray_frame: done %b sends %0d left %0d grants %0d expected 1 5 0 1",
               ok, sends_a - s0, q_a.size(), got_q_a.size());
    end
  endtask

  task automatic test_wide();
    bit ok = 1'b0;
    int s0 = sends_b;
    int d0 = dones_b;
    logic [7:0] exp_b[9] = '{8'hA1, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
    got_q_b.delete();
    req_data_b[1*64 +: 64] = 64'h0123456789ABCDEF;
    for (int i = 0; i < 9; i++) q_b.push_back(exp_b[i]);
    req_valid_b = 4'b0010;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      #1;
      ok = (got_q_b.size() >= 1);
    end
    tick();
    req_valid_b = '0;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      #1;
      ok = (dones_b >= d0 + 1);
    end
    repeat (3) @(negedge clk);
    tests += 2;
    if (!ok || sends_b - s0 != 9 || q_b.size() != 0) begin
      fails++;
      $display("FAIL wide_frame: done %b sends %0d left %0d expected 1 9 0", ok, sends_b - s0, q_b.size());
    end
    if (grant_id_b !== 2'd1 || dones_b - d0 != 1) begin
      fails++; $display("FAIL wide_grant: id %0d dones %0d expected 1 1", grant_id_b, dones_b - d0);
    end
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0;
    sends_a = 0; dones_a = 0; send_cyc_a = 0; err_cyc_a = 0;
    sends_b = 0; dones_b = 0;
    req_valid_a = '0; req_data_a = '0; err_clr_a = 1'b0;
    req_valid_b = '0; req_data_b = '0; err_clr_b = 1'b0;
    stray_a = 1'b0; uart_on_a = 1'b1;
    nreset = 1'b1;
    #1;
    nreset = 1'b0;
    test_reset();
    test_single();
    test_rr();
    test_timeout();
    test_reset_mid();
    test_stray();
    test_wide();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
